// File: rtl/trans_pkg.sv
// Shared definitions for the transfer address generator: opcode, instruction
// field layout, FSM state type and the port strobe helper.
package trans_pkg;

    localparam logic [2:0] OP_TRANS = 3'b000;

    localparam int OPC_LSB  = 24;
    localparam int OPC_W    = 3;
    localparam int ADDR_LSB = 12;
    localparam int ADDR_W   = 12;
    localparam int LEN_LSB  = 6;
    localparam int LEN_W    = 6;
    localparam int PORT_LSB = 4;
    localparam int PORT_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] port_onehot(input logic [PORT_W-1:0] port);
        logic [3:0] strobe;
        case (port)
            2'd0:    strobe = 4'b0001;
            2'd1:    strobe = 4'b0010;
            2'd2:    strobe = 4'b0100;
            2'd3:    strobe = 4'b1000;
            default: strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/trans_inst_decode.sv
// Combinational instruction field slicer with legal-opcode flag.
// The reserved low bits are deliberately not decoded.
module trans_inst_decode
    import trans_pkg::*;
#(
    parameter int INST_WIDTH = 27,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 6
) (
    input  logic [INST_WIDTH-1:0] inst,
    output logic [OPC_W-1:0]      opcode,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LEN_WIDTH-1:0]  length,
    output logic [PORT_W-1:0]     port,
    output logic                  legal
);

    assign opcode = inst[OPC_LSB +: OPC_W];
    assign addr   = inst[ADDR_LSB +: ADDR_WIDTH];
    assign length = inst[LEN_LSB +: LEN_WIDTH];
    assign port   = inst[PORT_LSB +: PORT_W];
    assign legal  = (opcode == OP_TRANS);

endmodule

// File: rtl/trans_addr_gen.sv
// Transfer address generator: accepts an instruction and emits one address
// beat per cycle on a one-hot port. Optional macro TRANS_QUEUE_EN adds a
// one-entry pending instruction register so transfers can run back to back.
module trans_addr_gen
    import trans_pkg::*;
#(
    parameter int INST_WIDTH = 27,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_en,
    output logic                  mem_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [LEN_WIDTH-1:0]    beat_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [3:0]              mem_en_r;
    logic                    mem_last_r;
    logic                    done_r;
    logic                    err_r;

    logic [INST_WIDTH-1:0]   dec_in_s;
    logic                    disp_s;
    logic [OPC_W-1:0]        dec_opcode_s;
    logic [ADDR_WIDTH-1:0]   dec_addr_s;
    logic [LEN_WIDTH-1:0]    dec_len_s;
    logic [PORT_W-1:0]       dec_port_s;
    logic                    dec_legal_s;
    logic [LEN_WIDTH-1:0]    beat_next_s;

`ifdef TRANS_QUEUE_EN
    logic                    pend_valid_r;
    logic [INST_WIDTH-1:0]   pend_inst_r;
    logic                    accept_s;
    logic                    from_pend_s;

    // Select the dispatch source: a pending entry always wins at DONE.
    always_comb begin
        accept_s    = inst_valid && !pend_valid_r;
        from_pend_s = pend_valid_r && (state_r == DONE);
        dec_in_s    = inst;
        disp_s      = 1'b0;
        if (from_pend_s) begin
            dec_in_s = pend_inst_r;
            disp_s   = 1'b1;
        end else if (accept_s && (state_r != RUN)) begin
            disp_s   = 1'b1;
        end else begin
            disp_s   = 1'b0;
        end
    end

    // Pending register captures instructions accepted while a beat stream runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid_r <= 1'b0;
            pend_inst_r  <= {INST_WIDTH{1'b0}};
        end else if (accept_s && (state_r == RUN)) begin
            pend_valid_r <= 1'b1;
            pend_inst_r  <= inst;
        end else if (from_pend_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    assign inst_ready = !pend_valid_r;
`else
    // Without the queue only IDLE may take a new instruction.
    always_comb begin
        dec_in_s = inst;
        if (inst_valid && (state_r == IDLE)) begin
            disp_s = 1'b1;
        end else begin
            disp_s = 1'b0;
        end
    end

    assign inst_ready = (state_r == IDLE);
`endif

    trans_inst_decode #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_decode (
        .inst   (dec_in_s),
        .opcode (dec_opcode_s),
        .addr   (dec_addr_s),
        .length (dec_len_s),
        .port   (dec_port_s),
        .legal  (dec_legal_s)
    );

    assign beat_next_s = beat_r + LEN_ONE;

    // Main FSM; every output is a register so beats appear the cycle after dispatch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            base_r     <= {ADDR_WIDTH{1'b0}};
            len_r      <= LEN_ZERO;
            beat_r     <= LEN_ZERO;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
            mem_en_r   <= 4'b0000;
            mem_last_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                RUN: begin
                    if (mem_last_r) begin
                        state_r    <= DONE;
                        mem_en_r   <= 4'b0000;
                        mem_last_r <= 1'b0;
                        done_r     <= 1'b1;
                    end else begin
                        beat_r     <= beat_next_s;
                        mem_addr_r <= base_r + ADDR_WIDTH'(beat_next_s);
                        mem_last_r <= (beat_next_s == (len_r - LEN_ONE));
                    end
                end
                IDLE, DONE: begin
                    if (disp_s && !dec_legal_s) begin
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                    end else if (disp_s && (dec_len_s == LEN_ZERO)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else if (disp_s) begin
                        state_r    <= RUN;
                        base_r     <= dec_addr_s;
                        len_r      <= dec_len_s;
                        beat_r     <= LEN_ZERO;
                        mem_addr_r <= dec_addr_s;
                        mem_en_r   <= port_onehot(dec_port_s);
                        mem_last_r <= (dec_len_s == LEN_ONE);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    mem_en_r   <= 4'b0000;
                    mem_last_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_r;
    assign mem_en   = mem_en_r;
    assign mem_last = mem_last_r;
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_trans_addr_gen.sv
// Directed self-checking bench for trans_addr_gen; the queued back-to-back
// case is exercised only when TRANS_QUEUE_EN is defined.
module tb_trans_addr_gen;

    logic        clk;
    logic        rstn;
    logic [26:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [11:0] mem_addr;
    logic [3:0]  mem_en;
    logic        mem_last;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

`ifdef TRANS_QUEUE_EN
    localparam logic QUEUE = 1'b1;
`else
    localparam logic QUEUE = 1'b0;
`endif

    trans_addr_gen dut (
        .clk        (clk),
        .rstn       (rstn),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_last   (mem_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input logic [2:0] op, input logic [11:0] a,
                                       input logic [5:0] len, input logic [1:0] p,
                                       input logic [3:0] rsvd);
        return {op, a, len, p, rsvd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [26:0] word);
        inst       = word;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [11:0] a,
                              input logic [3:0] en, input logic last);
        check({tag, " addr"}, 32'(mem_addr), 32'(a));
        check({tag, " en"}, 32'(mem_en), 32'(en));
        check({tag, " last"}, 32'(mem_last), 32'(last));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle en"}, 32'(mem_en), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle ready"}, 32'(inst_ready), 32'd1);
    endtask

    task automatic check_done(input string tag, input logic [11:0] held);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " done en"}, 32'(mem_en), 32'd0);
        check({tag, " done last"}, 32'(mem_last), 32'd0);
        check({tag, " done busy"}, 32'(busy), 32'd1);
        check({tag, " held addr"}, 32'(mem_addr), 32'(held));
    endtask

    initial begin
        rstn       = 1'b0;
        inst       = 27'd0;
        inst_valid = 1'b0;
        #12;
        check("rst addr", 32'(mem_addr), 32'd0);
        check("rst ready", 32'(inst_ready), 32'd1);
        check("rst err", 32'(err), 32'd0);
        check_idle("rst");
        rstn = 1'b1;
        tick();

        // addr 100, len 4, port 0, rsvd bits set and ignored
        send(mk(3'b000, 12'd100, 6'd4, 2'd0, 4'hF));
        for (int i = 0; i < 4; i++) begin
            check_beat("t1", 12'(100 + i), 4'b0001, (i == 3));
            check("t1 ready", 32'(inst_ready), 32'(QUEUE));
            tick();
        end
        check_done("t1", 12'd103);
        tick();
        check_idle("t1 after");

        // addr 200, len 2, port 2, with a stray valid during RUN
        send(mk(3'b000, 12'd200, 6'd2, 2'd2, 4'h0));
        check_beat("t2 b0", 12'd200, 4'b0100, 1'b0);
        if (!QUEUE) begin
            inst       = mk(3'b000, 12'd900, 6'd3, 2'd1, 4'h0);
            inst_valid = 1'b1;
        end
        tick();
        check_beat("t2 b1", 12'd201, 4'b0100, 1'b1);
        tick();
        inst_valid = 1'b0;
        check_done("t2", 12'd201);
        tick();
        check_idle("t2 after");
        tick();
        check_idle("t2 ignored");

        // address wrap at the top of the space
        send(mk(3'b000, 12'd4094, 6'd4, 2'd3, 4'h0));
        check_beat("t3 b0", 12'd4094, 4'b1000, 1'b0);
        tick();
        check_beat("t3 b1", 12'd4095, 4'b1000, 1'b0);
        tick();
        check_beat("t3 b2", 12'd0, 4'b1000, 1'b0);
        tick();
        check_beat("t3 b3", 12'd1, 4'b1000, 1'b1);
        tick();
        check_done("t3", 12'd1);
        tick();
        check_idle("t3 after");

        // zero-length transfer goes straight to DONE
        send(mk(3'b000, 12'd500, 6'd0, 2'd1, 4'h0));
        check_done("t4", 12'd1);
        tick();
        check_idle("t4 after");

        // illegal opcode pulses err for one cycle
        send(mk(3'b101, 12'd600, 6'd3, 2'd1, 4'h0));
        check("t5 err", 32'(err), 32'd1);
        check_idle("t5");
        tick();
        check("t5 err clear", 32'(err), 32'd0);
        check_idle("t5 after");

        // reset asserted during the second beat of a len-8 transfer
        send(mk(3'b000, 12'd300, 6'd8, 2'd1, 4'h0));
        check_beat("t6 b0", 12'd300, 4'b0010, 1'b0);
        tick();
        check_beat("t6 b1", 12'd301, 4'b0010, 1'b0);
        rstn = 1'b0;
        #1;
        check("t6 rst addr", 32'(mem_addr), 32'd0);
        check("t6 rst last", 32'(mem_last), 32'd0);
        check_idle("t6 rst");
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("t6 post");
            check("t6 post addr", 32'(mem_addr), 32'd0);
        end

`ifdef TRANS_QUEUE_EN
        // back-to-back transfers through the pending register
        send(mk(3'b000, 12'd100, 6'd2, 2'd0, 4'h0));
        check_beat("t7 a0", 12'd100, 4'b0001, 1'b0);
        inst       = mk(3'b000, 12'd200, 6'd2, 2'd0, 4'h0);
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        check_beat("t7 a1", 12'd101, 4'b0001, 1'b1);
        check("t7 ready full", 32'(inst_ready), 32'd0);
        tick();
        check_done("t7 a", 12'd101);
        tick();
        check_beat("t7 b0", 12'd200, 4'b0001, 1'b0);
        tick();
        check_beat("t7 b1", 12'd201, 4'b0001, 1'b1);
        tick();
        check_done("t7 b", 12'd201);
        tick();
        check_idle("t7 after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trans_addr_gen.md
TRANS_ADDR_GEN -- requirements
Module: trans_addr_gen

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 27, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 6, meaning transfer-length field width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port inst  input  INST_WIDTH  instruction word {opcode[26:24], addr[23:12], length[11:6], port[5:4], rsvd[3:0]}.
REQ-007 SHALL have port inst_valid  input  1  inst is valid this cycle.
REQ-008 SHALL have port inst_ready  output  1  block accepts inst this cycle.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  current transfer address.
REQ-010 SHALL have port mem_en  output  4  one-hot memory port strobe.
REQ-011 SHALL have port mem_last  output  1  final beat of the transfer.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  one-cycle illegal-opcode pulse.

Function
REQ-015 Accept SHALL occur on a rising edge with inst_valid && inst_ready; rsvd bits SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; inst_ready SHALL be 1 only in IDLE (queue off).
REQ-017 Accept of opcode 3'b000 with length>0 SHALL latch addr/length/port and enter RUN; first beat on the cycle after accept.
REQ-018 Each RUN cycle SHALL drive mem_en[port]=1 (other bits 0), mem_addr=base+beat, beat counting 0..length-1.
REQ-019 Address SHALL wrap modulo 2^ADDR_WIDTH (4095+1 -> 0).
REQ-020 mem_last SHALL be 1 only on beat length-1; the next cycle SHALL be DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then IDLE; total occupancy length+2 cycles.
REQ-022 Accept of opcode 3'b000 with length=0 SHALL go IDLE->DONE with no mem_en beats.
REQ-023 Accept of any other opcode SHALL pulse err for the cycle after accept, stay IDLE, no beats.
REQ-024 busy SHALL equal 1 in RUN and DONE, 0 in IDLE.
REQ-025 Outside RUN, mem_en and mem_last SHALL be 0 and mem_addr SHALL hold its last value.
REQ-026 inst_valid while inst_ready=0 SHALL be ignored without side effects.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE, inst_ready=1, mem_addr=0, mem_en=0, mem_last=0, busy=0, done=0, err=0, counters 0.
REQ-028 Reset mid-RUN SHALL abort the transfer without a done pulse; no beats after rstn rises until a new accept.

Configuration
REQ-029 Macro TRANS_QUEUE_EN SHALL, when defined, add a one-entry pending instruction register.
REQ-030 With TRANS_QUEUE_EN: inst_ready=1 whenever pending is empty (any state); on DONE with pending valid, pending SHALL be dispatched with RUN (or DONE if length=0, err if illegal) in the next cycle, skipping IDLE.
REQ-031 Without TRANS_QUEUE_EN: behaviour exactly per REQ-016; no pending register synthesized.
REQ-032 Pending register SHALL be cleared by reset.

Structure
REQ-033 Package trans_pkg SHALL hold OP_TRANS=3'b000, instruction field bit offsets/widths, and the FSM state typedef.
REQ-034 Sub-module trans_inst_decode (combinational field slicer + legal-opcode flag) SHALL be instantiated once.

Verification
REQ-035 addr=100, len=4, port=0 -> mem_en=0001 with addr 100,101,102,103 on cycles 1-4 after accept, mem_last on 103, done cycle 5.
REQ-036 addr=200, len=2, port=2 -> mem_en=0100 with addr 200,201, mem_last on 201, done next cycle.
REQ-037 addr=4094, len=4, port=3 -> addresses 4094,4095,0,1 on mem_en=1000.
REQ-038 len=0 -> done 1 cycle after accept, zero beats; opcode 3'b101 -> err pulse, zero beats, inst_ready stays 1.
REQ-039 rstn low during beat 2 of len=8 -> all outputs at reset values immediately, no done, idle after release.
REQ-040 TRANS_QUEUE_EN: back-to-back accepts (100,len 2) then (200,len 2) -> beats 100,101, done, beats 200,201 without IDLE cycle.
